// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : boot-time byte-stream loader that fills instruction memory
//               and holds the rv32 core in reset until the image verifies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // LEN is compared in 17 bits so a full 2**ADDR_W image is still legal
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_widx;
  logic [1:0]        r_bidx;
  logic [7:0]        r_xor;
  logic [23:0]       r_buf;

  logic              w_xfer;
  logic [16:0]       w_len_full;
  logic [ADDR_W:0]   w_widx_next;
  logic              w_last;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_len_full  = {1'b0, rx_data, r_len[7:0]};
  assign w_widx_next = r_widx + 1'b1;
  assign w_last      = (17'(w_widx_next) == {1'b0, r_len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LEN0;
      r_len      <= '0;
      r_widx     <= '0;
      r_bidx     <= '0;
      r_xor      <= '0;
      r_buf      <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_LEN0: begin
          if (w_xfer) begin
            r_len[7:0] <= rx_data;
            r_xor      <= r_xor ^ rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_xfer) begin
            r_len[15:8] <= rx_data;
            r_xor       <= r_xor ^ rx_data;
            if (w_len_full > MAX_LEN) begin
              r_state  <= S_ERR;
              err      <= 1'b1;
              rx_ready <= 1'b0;
            end else if (w_len_full == '0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_xor  <= r_xor ^ rx_data;
            r_bidx <= r_bidx + 2'd1;
            case (r_bidx)
              2'd0: r_buf[7:0]   <= rx_data;
              2'd1: r_buf[15:8]  <= rx_data;
              2'd2: r_buf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= r_widx[ADDR_W-1:0];
                imem_wdata <= {rx_data, r_buf};
                r_widx     <= w_widx_next;
                if (w_last) begin
                  r_state <= S_CSUM;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == r_xor) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            r_state  <= S_LEN0;
            done     <= 1'b0;
            err      <= 1'b0;
            core_rst <= 1'b1;
            rx_ready <= 1'b1;
            r_widx   <= '0;
            r_bidx   <= '0;
            r_xor    <= '0;
          end
        end
        default: r_state <= S_LEN0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the rv32 core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into instruction memory and holds the core in reset until a complete, checksum-verified image has been loaded. On success it releases the core; on failure it keeps the core in reset and flags an error.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity is 2**ADDR_W words
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-high reset
- rx_valid  input  1  byte-stream valid
- rx_data  input  8  byte-stream data
- rx_ready  output  1  loader accepts a byte; a transfer happens on a cycle where rx_valid && rx_ready
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERR
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  write data
- core_rst  output  1  active-high reset to the rv32 core
- done  output  1  image loaded and verified
- err  output  1  load failed: length overflow or checksum mismatch

## Operation
- Stream format: LEN_LO, LEN_HI, then LEN×4 payload bytes, then CSUM. LEN is a 16-bit count of words. Payload words are little-endian, so the first byte is bits 7:0.
- CSUM is the 8-bit XOR of every preceding byte, including both LEN bytes.
- States: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR.
- S_LEN0: on a transfer, latch LEN_LO and go to S_LEN1.
- S_LEN1: on a transfer, latch LEN_HI.
  - LEN > 2**ADDR_W: go to S_ERR.
  - LEN == 0: go to S_CSUM.
  - Otherwise: go to S_DATA.
- S_DATA: a 2-bit byte index counts transferred bytes.
  - On the 4th byte, write {b3,b2,b1,b0} at the current word index, then increment the word index.
  - After word LEN−1 is written, go to S_CSUM.
- S_CSUM: on a transfer, compare the byte with the running XOR.
  - Equal: go to S_DONE.
  - Not equal: go to S_ERR.
- S_DONE: core_rst=0, done=1, rx_ready=0.
- S_ERR: core_rst=1, err=1, rx_ready=0.
- reload is honoured only in S_DONE and S_ERR. It clears done, err, the word index, the byte index and the XOR; sets core_rst=1; and enters S_LEN0. reload in any other state is ignored.
- No rollback: words written before an error stay in memory.
- rx_ready is 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM. The loader never back-pressures mid-image.
- Width rules:
  - The word index is ADDR_W+1 bits, so LEN == 2**ADDR_W is legal.
  - imem_addr carries the low ADDR_W bits.
  - The XOR is 8 bits with no carry.

## Timing
- Reset values:
  - state S_LEN0
  - rx_ready=1
  - imem_we=0, imem_addr=0, imem_wdata=0
  - core_rst=1, done=0, err=0
  - all counters and the XOR at 0
- Asynchronous reset at any point, including mid-word or mid-image, forces reset values immediately. A partially assembled word is discarded.
- Write latency: imem_we, imem_addr and imem_wdata are registered. They are valid for exactly one cycle, the cycle after the 4th-byte transfer. imem_we is 0 at all other times.
- Back-to-back bytes, one per cycle, are accepted at full rate, so the maximum write rate is one word per 4 cycles.
- After the CSUM transfer, done/core_rst (match) or err (mismatch) change on the next edge.
- A stalled stream (rx_valid=0) holds all state. There is no timeout.
- After a reload pulse, core_rst=1 and rx_ready=1 on the next edge.

## Test plan
- LEN=2, words 0x00500093 and 0x00A00113, correct CSUM (0x02^0x00^all payload bytes) at one byte per cycle:
  - imem_we pulses at addr 0 then addr 1 with those data values.
  - done=1 and core_rst=0 one cycle after the CSUM transfer.
- Same image with rx_valid toggling every other cycle: identical writes and the same final state.
- Correct image but CSUM flipped in bit 0: both words are written, then err=1, core_rst stays 1, done=0, rx_ready=0.
- LEN=0x0401 with ADDR_W=10: S_ERR right after LEN_HI, no imem_we pulses, err=1. LEN=0x0400 with a valid image is accepted, and the last write is at addr 0x3FF.
- LEN=0 followed by CSUM=0x00: done=1 and no writes. A reload pulse then returns core_rst to 1, done to 0 and rx_ready to 1, and a second image loads correctly.
- rst asserted after 2 of 4 bytes of word 1:
  - All outputs take reset values asynchronously.
  - No write happens at addr 1.
  - A following full image loads from addr 0.
